sensor_rd_seq: RTL
==================

SENSOR_RD_SEQ -- requirements
Module: sensor_rd_seq

Interface
REQ-001 Parameter PWR_DLY_W, default 16, width of the power-up delay counter (delay = 2^PWR_DLY_W clk cycles).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 INT  input  1  sensor data-ready, asynchronous to clk.
REQ-005 done  input  1  SPI master completion level; set at end of transaction, cleared after next wrt.
REQ-006 rd_data  input  16  SPI master read word; byte of interest in [7:0].
REQ-007 wrt  output  1  one-cycle pulse starting an SPI transaction.
REQ-008 cmd  output  16  registered SPI command word, stable from wrt until done rises.
REQ-009 axis_x  output  16  latest X reading {high byte, low byte}.
REQ-010 axis_y  output  16  latest Y reading {high byte, low byte}.
REQ-011 vld  output  1  one-cycle pulse when axis_x/axis_y update.
REQ-012 init_done  output  1  level, high once the configuration sequence completes.

Function
REQ-013 States SHALL be PWR, INIT, INIT_W, IDLE, READ, READ_W.
REQ-014 PWR: counter increments each cycle; on all-ones go to INIT, counter held afterwards.
REQ-015 INIT: assert wrt with cmd = CFG[idx] (CFG0 16'h0D02, CFG1 16'h1062, CFG2 16'h1162), go to INIT_W.
REQ-016 INIT_W: on done rising edge (done high, previous-cycle done low) idx++; idx==3 -> IDLE and set init_done, else INIT.
REQ-017 Completion SHALL be detected only by done rising edge, never by done level, so a stale high done is ignored.
REQ-018 INT SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal sets pending.
REQ-019 IDLE: if pending, clear pending, idx=0, go to READ.
REQ-020 READ: assert wrt with cmd = RD[idx] (RD0 16'hA2xx XL, RD1 16'hA3xx XH, RD2 16'hA4xx YL, RD3 16'hA5xx YH; xx = 8'h00), go to READ_W.
REQ-021 READ_W: on done rising edge store rd_data[7:0] into holding byte idx; idx==3 -> IDLE, else idx++ and READ.
REQ-022 axis_x and axis_y SHALL update together in the cycle after the fourth byte is stored, with vld high that cycle only.
REQ-023 INT edge arriving during INIT/READ/READ_W SHALL set pending (single depth; further edges merge) and be serviced at next IDLE.
REQ-024 INT edges before init_done SHALL be discarded; pending cleared on entering IDLE from INIT_W.
REQ-025 wrt SHALL never assert in consecutive cycles; minimum one idle cycle between transactions.
REQ-026 Latency INT rise -> first wrt: 4 cycles (2 sync, 1 edge, 1 IDLE) when IDLE.

Reset
REQ-027 rst_n low, any state: state PWR, counter 0, idx 0, pending 0, wrt 0, cmd 16'h0000, axis_x/axis_y 16'h0000, vld 0, init_done 0, sync flops 0, done-delay flop 0.
REQ-028 Reset mid-transaction SHALL abandon it; full power-up and configuration sequence reruns after release.

Structure
REQ-029 Shared package sensor_pkg SHALL hold state enum and CFG/RD command constants.
REQ-030 Sub-module int_sync (2-flop synchronizer plus rising-edge detect, 1-cycle pulse out) SHALL be instantiated for INT.

Verification
REQ-031 Reset release, PWR_DLY_W=4, done returned 30 cycles after each wrt -> wrt at cycle 16, cmds 0D02,1062,1162 in order, init_done after third done edge.
REQ-032 After init, INT pulse, model returns bytes 34,12,78,56 -> cmds A200,A300,A400,A500, axis_x=16'h1234, axis_y=16'h5678, vld one cycle.
REQ-033 Three INT edges during one read burst -> exactly one further burst, two vld pulses total.
REQ-034 done held high from previous transaction when wrt issues -> no advance until done falls and rises again.
REQ-035 rst_n asserted during READ_W of byte 2 -> all outputs to reset values immediately; rerun shows config writes before any read.
REQ-036 INT pulse during PWR -> no read burst after init_done.

Source files
------------

// File: rtl/sensor_rd_seq_pkg.sv
// sensor_pkg: shared types and command words for the sensor read sequencer.
//   state_t  - sequencer FSM states
//   CFG*/RD* - SPI command words for configuration writes and axis reads
//   cfg_cmd / rd_cmd - map a transaction index to its command word
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_INIT_W,
    ST_IDLE,
    ST_READ,
    ST_READ_W
  } state_t;

  localparam logic [15:0] CFG0 = 16'h0D02;
  localparam logic [15:0] CFG1 = 16'h1062;
  localparam logic [15:0] CFG2 = 16'h1162;

  localparam logic [15:0] RD0 = 16'hA200;  // X low
  localparam logic [15:0] RD1 = 16'hA300;  // X high
  localparam logic [15:0] RD2 = 16'hA400;  // Y low
  localparam logic [15:0] RD3 = 16'hA500;  // Y high

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd1:    return CFG1;
      2'd2:    return CFG2;
      default: return CFG0;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
    case (idx)
      2'd1:    return RD1;
      2'd2:    return RD2;
      2'd3:    return RD3;
      default: return RD0;
    endcase
  endfunction

endpackage

// File: rtl/sensor_rd_seq_if.sv
// sensor_rd_seq_if: SPI-master command/response bundle.
//   wrt     - one-cycle transaction start (sequencer -> SPI master)
//   cmd     - 16-bit command word (sequencer -> SPI master)
//   done    - completion level (SPI master -> sequencer)
//   rd_data - read word, byte of interest in [7:0] (SPI master -> sequencer)
interface sensor_rd_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, cmd, input done, rd_data);
  modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/sensor_rd_seq_int_sync.sv
// int_sync: 2-flop synchronizer for an asynchronous level plus a registered
// rising-edge detector.
//   clk, rst_n - clock, async active-low reset
//   i_async    - asynchronous input
//   o_pulse    - one-cycle pulse per rising edge of the synchronized input
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_sync1, r_sync2, r_sync3, r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_pulse <= r_sync2 & ~r_sync3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sensor_rd_seq.sv
// sensor_rd_seq: power-up delay, three configuration writes, then one
// four-byte axis read burst per sensor data-ready (INT) edge.
//   clk, rst_n          - clock, async active-low reset
//   i_int               - sensor data-ready, asynchronous
//   spi                 - SPI master bundle (wrt/cmd out, done/rd_data in)
//   o_axis_x, o_axis_y  - latest readings {high, low}
//   o_vld               - one-cycle pulse when the axis outputs update
//   o_init_done         - high once configuration has completed
//
// state     | meaning
// ST_PWR    | power-up delay counting
// ST_INIT   | config write issued (wrt high)
// ST_INIT_W | waiting for config write completion
// ST_IDLE   | configured, waiting for a pending INT
// ST_READ   | axis byte read issued (wrt high)
// ST_READ_W | waiting for axis byte read completion
module sensor_rd_seq
  import sensor_pkg::*;
#(
  parameter int PWR_DLY_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_int,
  sensor_rd_seq_if.master        spi,
  output logic [15:0]            o_axis_x,
  output logic [15:0]            o_axis_y,
  output logic                   o_vld,
  output logic                   o_init_done
);

  state_t                 r_state, w_state_nxt;
  logic [PWR_DLY_W-1:0]   r_cnt;
  logic [1:0]             r_idx, w_idx_nxt;
  logic                   r_pending, w_pending_nxt;
  logic                   r_wrt, w_wrt_nxt;
  logic [15:0]            r_cmd, w_cmd_nxt;
  logic                   r_init_done, w_init_done_nxt;
  logic                   r_done_d;
  logic [3:0][7:0]        r_hold;
  logic                   r_upd, w_upd_nxt;
  logic                   w_store;
  logic [15:0]            r_axis_x, r_axis_y;
  logic                   r_vld;
  logic                   w_int_pulse;
  logic                   w_done_rise;
  logic                   w_unused_rd_hi;

  int_sync u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_int),
    .o_pulse (w_int_pulse)
  );

  // Only an edge counts as completion; a done level left over from the
  // previous transaction must not advance the sequence.
  assign w_done_rise    = spi.done & ~r_done_d;
  assign w_unused_rd_hi = ^spi.rd_data[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PWR;
    else        r_state <= w_state_nxt;
  end

  // wrt/cmd are registered from the next-state decode so wrt is high exactly
  // for the cycle spent in ST_INIT / ST_READ.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pending_nxt   = r_pending | (w_int_pulse && (r_state != ST_IDLE));
    w_wrt_nxt       = 1'b0;
    w_cmd_nxt       = r_cmd;
    w_init_done_nxt = r_init_done;
    w_upd_nxt       = 1'b0;
    w_store         = 1'b0;
    case (r_state)
      ST_PWR: begin
        if (&r_cnt) begin
          w_state_nxt = ST_INIT;
          w_wrt_nxt   = 1'b1;
          w_cmd_nxt   = cfg_cmd(r_idx);
        end
      end
      ST_INIT: w_state_nxt = ST_INIT_W;
      ST_INIT_W: begin
        if (w_done_rise) begin
          if (r_idx == 2'd2) begin
            w_state_nxt     = ST_IDLE;
            w_idx_nxt       = 2'd0;
            w_pending_nxt   = 1'b0;  // INT seen before configuration is dropped
            w_init_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_INIT;
            w_idx_nxt   = r_idx + 2'd1;
            w_wrt_nxt   = 1'b1;
            w_cmd_nxt   = cfg_cmd(r_idx + 2'd1);
          end
        end
      end
      ST_IDLE: begin
        if (r_pending || w_int_pulse) begin
          w_state_nxt   = ST_READ;
          w_pending_nxt = 1'b0;
          w_idx_nxt     = 2'd0;
          w_wrt_nxt     = 1'b1;
          w_cmd_nxt     = rd_cmd(2'd0);
        end
      end
      ST_READ: w_state_nxt = ST_READ_W;
      ST_READ_W: begin
        if (w_done_rise) begin
          w_store = 1'b1;
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_IDLE;
            w_upd_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_READ;
            w_idx_nxt   = r_idx + 2'd1;
            w_wrt_nxt   = 1'b1;
            w_cmd_nxt   = rd_cmd(r_idx + 2'd1);
          end
        end
      end
      default: w_state_nxt = ST_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_pending   <= 1'b0;
      r_wrt       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_init_done <= 1'b0;
      r_done_d    <= 1'b0;
      r_hold      <= '0;
      r_upd       <= 1'b0;
      r_axis_x    <= 16'h0000;
      r_axis_y    <= 16'h0000;
      r_vld       <= 1'b0;
    end else begin
      if ((r_state == ST_PWR) && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      r_idx       <= w_idx_nxt;
      r_pending   <= w_pending_nxt;
      r_wrt       <= w_wrt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_init_done <= w_init_done_nxt;
      r_done_d    <= spi.done;
      if (w_store) r_hold[r_idx] <= spi.rd_data[7:0];
      // Both axes move together one cycle after the last byte lands.
      r_upd <= w_upd_nxt;
      r_vld <= r_upd;
      if (r_upd) begin
        r_axis_x <= {r_hold[1], r_hold[0]};
        r_axis_y <= {r_hold[3], r_hold[2]};
      end
    end
  end

  assign spi.wrt     = r_wrt;
  assign spi.cmd     = r_cmd;
  assign o_axis_x    = r_axis_x;
  assign o_axis_y    = r_axis_y;
  assign o_vld       = r_vld;
  assign o_init_done = r_init_done;

endmodule
